multicyc_ctrl_fsm: RTL
======================

MULTICYC_CTRL_FSM -- requirements
Module: multicyc_ctrl_fsm

Interface
REQ-001 SHALL provide one clock and an asynchronous, active-high reset, ports iClk and iRst.
REQ-002 iClk  input  1  rising-edge clock for all state.
REQ-003 iRst  input  1  asynchronous active-high reset; forces state IDLE immediately.
REQ-004 iOpCode  input  6  instruction[31:26], valid from DECODE onward.
REQ-005 iFunct  input  6  instruction[5:0].
REQ-006 iAluZero  input  1  ALU zero flag, same cycle.
REQ-007 iMemReady  input  1  memory done; samples with oMemRead/oMemWrite.
REQ-008 oPCWrite  output  1  load PC this edge.
REQ-009 oPCSrc  output  2  PC source: 00 ALU result, 01 ALUOut reg, 10 jump target, 11 rs data.
REQ-010 oIorD  output  1  memory address: 1 ALUOut, 0 PC.
REQ-011 oMemRead, oMemWrite  output  1 each  memory strobes.
REQ-012 oIRWrite  output  1  load instruction register.
REQ-013 oRegWrite  output  1  register-file write enable.
REQ-014 oRegDst  output  1  write index: 1 rd, 0 rt.
REQ-015 oMemtoReg  output  1  write data: 1 memory data reg, 0 ALUOut.
REQ-016 oLink  output  1  write PC to r31; overrides oRegDst/oMemtoReg.
REQ-017 oALUSrcA  output  1  ALU A: 0 PC, 1 rs data.
REQ-018 oALUSrcB  output  2  ALU B: 00 rt data, 01 constant 4, 10 sext imm, 11 sext imm<<2.
REQ-019 oALUOp  output  2  00 add, 01 sub, 10 decode funct, 11 decode opcode.
REQ-020 oIllegal  output  1  one-cycle pulse on unsupported opcode.
REQ-021 oState  output  4  current state code, for debug.

Function
REQ-022 States and codes: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC_R 7, RWB 8, EXEC_I 9, IWB 10, BRANCH 11, JUMP 12, JREG 13, ILLEGAL 14; code 15 -> IDLE next edge.
REQ-023 Outputs are combinational from state (and iAluZero, iMemReady, iFunct); unlisted outputs are 0 in every state.
REQ-024 IDLE: all outputs 0; next FETCH unconditionally.
REQ-025 FETCH: oMemRead=1, oIorD=0, oALUSrcA=0, oALUSrcB=01, oALUOp=00, oPCSrc=00; oIRWrite=oPCWrite=iMemReady; stay while iMemReady=0, then DECODE.
REQ-026 DECODE: oALUSrcA=0, oALUSrcB=11, oALUOp=00 (branch target to ALUOut); next by opcode: 0x23/0x2B MEMADR; 0x00 with funct 0x08/0x09 JREG, other funct EXEC_R; 0x08-0x0D, 0x0F EXEC_I; 0x04/0x05 BRANCH; 0x02/0x03 JUMP; else ILLEGAL.
REQ-027 MEMADR: oALUSrcA=1, oALUSrcB=10, oALUOp=00; next MEMRD for 0x23, MEMWR for 0x2B.
REQ-028 MEMRD: oMemRead=1, oIorD=1; hold until iMemReady=1, then MEMWB.
REQ-029 MEMWB: oRegWrite=1, oRegDst=0, oMemtoReg=1; next FETCH.
REQ-030 MEMWR: oMemWrite=1, oIorD=1; hold until iMemReady=1, then FETCH.
REQ-031 EXEC_R: oALUSrcA=1, oALUSrcB=00, oALUOp=10; next RWB. RWB: oRegWrite=1, oRegDst=1, oMemtoReg=0; next FETCH.
REQ-032 EXEC_I: oALUSrcA=1, oALUSrcB=10, oALUOp=11; next IWB. IWB: oRegWrite=1, oRegDst=0; next FETCH.
REQ-033 BRANCH: oALUSrcA=1, oALUSrcB=00, oALUOp=01, oPCSrc=01; oPCWrite = iAluZero for 0x04, ~iAluZero for 0x05; next FETCH.
REQ-034 JUMP: oPCSrc=10, oPCWrite=1; oLink=oRegWrite=1 only for 0x03; next FETCH.
REQ-035 JREG: oPCSrc=11, oPCWrite=1; oLink=oRegWrite=1 only for funct 0x09; next FETCH.
REQ-036 ILLEGAL: oIllegal=1, no writes; next FETCH (instruction acts as NOP).
REQ-037 Latency with iMemReady tied 1: LW 5 cycles, SW/R/I-type 4, BEQ/BNE/J/JAL/JR/JALR 3.
REQ-038 Each memory wait cycle adds exactly one cycle; oMemRead/oMemWrite stay asserted and address selection stable throughout the wait.
REQ-039 oRegWrite, oPCWrite, oMemWrite never assert in IDLE or ILLEGAL.

Reset
REQ-040 iRst=1 asynchronously forces IDLE and all outputs 0 (oState=0) without a clock edge; mid-instruction reset abandons the instruction with no further writes.
REQ-041 First rising edge after iRst deasserts enters FETCH.

Verification
REQ-042 Reset release, ready=1, opcode 0x00 funct 0x20: oState 1,2,7,8,1; oRegWrite=1 with oRegDst=1 only in state 8.
REQ-043 LW (0x23), ready low 2 cycles in MEMRD: states 1,2,3,4,4,4,5,1; oMemRead=1, oIorD=1 all three MEMRD cycles.
REQ-044 BEQ (0x04) zero=1 -> oPCWrite=1, oPCSrc=01 in BRANCH; BNE (0x05) zero=1 -> oPCWrite=0.
REQ-045 JAL (0x03) -> JUMP with oPCWrite=oLink=oRegWrite=1, oPCSrc=10; JALR funct 0x09 -> JREG, oPCSrc=11, oLink=1.
REQ-046 Opcode 0x3F -> ILLEGAL, oIllegal pulses one cycle, no write strobes, then FETCH.
REQ-047 iRst asserted mid-MEMWR with ready=0 -> oMemWrite drops same cycle, oState=0, FETCH one edge after release.

Source files
------------

// File: rtl/multicyc_ctrl_fsm.sv
// Multi-cycle MIPS-style control unit: state register plus a combinational
// decode of state (and ALU-zero / memory-ready / funct) into datapath controls.
module multicyc_ctrl_fsm (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [5:0] iOpCode,
  input  logic [5:0] iFunct,
  input  logic       iAluZero,
  input  logic       iMemReady,
  output logic       oPCWrite,
  output logic [1:0] oPCSrc,
  output logic       oIorD,
  output logic       oMemRead,
  output logic       oMemWrite,
  output logic       oIRWrite,
  output logic       oRegWrite,
  output logic       oRegDst,
  output logic       oMemtoReg,
  output logic       oLink,
  output logic       oALUSrcA,
  output logic [1:0] oALUSrcB,
  output logic [1:0] oALUOp,
  output logic       oIllegal,
  output logic [3:0] oState
);

  localparam int unsigned STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    EXEC_R  = 4'd7,
    RWB     = 4'd8,
    EXEC_I  = 4'd9,
    IWB     = 4'd10,
    BRANCH  = 4'd11,
    JUMP    = 4'd12,
    JREG    = 4'd13,
    ILLEGAL = 4'd14
  } state_e;

  state_e state_q, state_d;

  // State register; reset lands in IDLE without waiting for a clock edge.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign oState = STATE_W'(state_q);

  always_comb begin
    state_d   = state_q;
    oPCWrite  = 1'b0;
    oPCSrc    = 2'b00;
    oIorD     = 1'b0;
    oMemRead  = 1'b0;
    oMemWrite = 1'b0;
    oIRWrite  = 1'b0;
    oRegWrite = 1'b0;
    oRegDst   = 1'b0;
    oMemtoReg = 1'b0;
    oLink     = 1'b0;
    oALUSrcA  = 1'b0;
    oALUSrcB  = 2'b00;
    oALUOp    = 2'b00;
    oIllegal  = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      // PC+4 is computed while the instruction is read; both commit on ready.
      FETCH: begin
        oMemRead = 1'b1;
        oALUSrcB = 2'b01;
        oIRWrite = iMemReady;
        oPCWrite = iMemReady;
        state_d  = iMemReady ? DECODE : FETCH;
      end

      // Branch target is precomputed into ALUOut while the opcode decodes.
      DECODE: begin
        oALUSrcB = 2'b11;
        if (iOpCode == OP_LW || iOpCode == OP_SW) begin
          state_d = MEMADR;
        end else if (iOpCode == OP_RTYPE) begin
          state_d = (iFunct == FN_JR || iFunct == FN_JALR) ? JREG : EXEC_R;
        end else if ((iOpCode >= OP_ADDI && iOpCode <= OP_XORI - 6'd1) || iOpCode == OP_LUI) begin
          state_d = EXEC_I;
        end else if (iOpCode == OP_BEQ || iOpCode == OP_BNE) begin
          state_d = BRANCH;
        end else if (iOpCode == OP_J || iOpCode == OP_JAL) begin
          state_d = JUMP;
        end else begin
          state_d = ILLEGAL;
        end
      end

      MEMADR: begin
        oALUSrcA = 1'b1;
        oALUSrcB = 2'b10;
        state_d  = (iOpCode == OP_LW) ? MEMRD : MEMWR;
      end

      MEMRD: begin
        oMemRead = 1'b1;
        oIorD    = 1'b1;
        state_d  = iMemReady ? MEMWB : MEMRD;
      end

      MEMWB: begin
        oRegWrite = 1'b1;
        oMemtoReg = 1'b1;
        state_d   = FETCH;
      end

      MEMWR: begin
        oMemWrite = 1'b1;
        oIorD     = 1'b1;
        state_d   = iMemReady ? FETCH : MEMWR;
      end

      EXEC_R: begin
        oALUSrcA = 1'b1;
        oALUOp   = 2'b10;
        state_d  = RWB;
      end

      RWB: begin
        oRegWrite = 1'b1;
        oRegDst   = 1'b1;
        state_d   = FETCH;
      end

      EXEC_I: begin
        oALUSrcA = 1'b1;
        oALUSrcB = 2'b10;
        oALUOp   = 2'b11;
        state_d  = IWB;
      end

      IWB: begin
        oRegWrite = 1'b1;
        state_d   = FETCH;
      end

      BRANCH: begin
        oALUSrcA = 1'b1;
        oALUOp   = 2'b01;
        oPCSrc   = 2'b01;
        oPCWrite = (iOpCode == OP_BEQ &&  iAluZero) ||
                   (iOpCode == OP_BNE && !iAluZero);
        state_d  = FETCH;
      end

      JUMP: begin
        oPCSrc    = 2'b10;
        oPCWrite  = 1'b1;
        oLink     = (iOpCode == OP_JAL);
        oRegWrite = (iOpCode == OP_JAL);
        state_d   = FETCH;
      end

      JREG: begin
        oPCSrc    = 2'b11;
        oPCWrite  = 1'b1;
        oLink     = (iFunct == FN_JALR);
        oRegWrite = (iFunct == FN_JALR);
        state_d   = FETCH;
      end

      ILLEGAL: begin
        oIllegal = 1'b1;
        state_d  = FETCH;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
